// File: rtl/siso_decoder_pkg.sv
// Shared constants and types for the SISO decoder blocks: default geometry,
// branch-metric FSM encoding and the guard width used by the saturating datapath.
package siso_decoder_pkg;

    localparam int DWIDTH_DEF   = 16;
    localparam int ROW_SIZE_DEF = 3072;
    // Three DWIDTH operands summed need two extra bits before the halving shift.
    localparam int SAT_GUARD    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } bm_state_t;

endpackage

// File: rtl/bm_sat_shift.sv
// Two-stage add / arithmetic-halve / saturate slice for one branch metric.
// PAR_SUB selects whether the parity LLR is added (branch1) or subtracted (branch2).
module bm_sat_shift
    import siso_decoder_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter bit PAR_SUB = 1'b0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DWIDTH-1:0] i_sys,
    input  logic [DWIDTH-1:0] i_apr,
    input  logic [DWIDTH-1:0] i_par,
    output logic [DWIDTH-1:0] o_branch
);

    localparam int SW = DWIDTH + SAT_GUARD;

    logic signed [SW-1:0] sys_x;
    logic signed [SW-1:0] apr_x;
    logic signed [SW-1:0] par_x;
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_q;
    logic signed [SW-1:0] shr;
    logic                 in_range;
    logic [DWIDTH-1:0]    sat;

    always_comb begin
        sys_x = {{SAT_GUARD{i_sys[DWIDTH-1]}}, i_sys};
        apr_x = {{SAT_GUARD{i_apr[DWIDTH-1]}}, i_apr};
        par_x = {{SAT_GUARD{i_par[DWIDTH-1]}}, i_par};
        sum_d = PAR_SUB ? (sys_x + apr_x - par_x) : (sys_x + apr_x + par_x);
    end

    // Arithmetic shift floors toward minus infinity; the value fits DWIDTH only
    // when every bit from the DWIDTH sign position upward agrees.
    always_comb begin
        shr      = sum_q >>> 1;
        in_range = (&shr[SW-1:DWIDTH-1]) || (~|shr[SW-1:DWIDTH-1]);
        if (in_range) begin
            sat = shr[DWIDTH-1:0];
        end else if (shr[SW-1]) begin
            sat = {1'b1, {(DWIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DWIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sum_q    <= '0;
            o_branch <= '0;
        end else begin
            if (i_load) begin
                sum_q <= sum_d;
            end
            if (i_shift) begin
                o_branch <= sat;
            end
        end
    end

endmodule

// File: rtl/branch_metric_block.sv
// Branch-metric front end of the SISO decoder: counts trellis steps per frame,
// checks frame framing against s_last and streams saturated branch pairs to the alpha rows.
module branch_metric_block
    import siso_decoder_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int ROW_SIZE = ROW_SIZE_DEF,
    localparam int AW      = $clog2(ROW_SIZE)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              i_start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_sys,
    input  logic [DWIDTH-1:0] s_par,
    input  logic [DWIDTH-1:0] s_apr,
    input  logic              s_last,
    output logic              o_valid,
    output logic [AW-1:0]     o_addr,
    output logic [DWIDTH-1:0] o_branch1,
    output logic [DWIDTH-1:0] o_branch2,
    output logic              o_done,
    output logic              o_err,
    output bm_state_t         dbg_state
);

    localparam logic [AW-1:0] K_LAST = AW'(ROW_SIZE - 1);

    bm_state_t     state_q;
    bm_state_t     state_d;
    logic [AW-1:0] k_q;
    logic [AW-1:0] addr1_q;
    logic          v1_q;
    logic          last1_q;
    logic          accept;
    logic          k_is_last;
    logic          start_acc;

    // Handshake: a sample transfers on any cycle with s_valid && s_ready; s_ready
    // depends only on state. The output side has no ready: o_valid is a strobe
    // and o_addr/o_branch* keep their last value while it is low.
    assign s_ready   = (state_q == ST_RUN);
    assign accept    = s_valid && s_ready;
    assign k_is_last = (k_q == K_LAST);
    assign start_acc = (state_q == ST_IDLE) && i_start;
    assign dbg_state = state_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_RUN;
            ST_RUN:   if (accept && k_is_last) state_d = ST_FLUSH;
            ST_FLUSH: if (o_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Framing errors are only flagged; the frame length is fixed by the counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            k_q   <= '0;
            o_err <= 1'b0;
        end else if (start_acc) begin
            k_q   <= '0;
            o_err <= 1'b0;
        end else if (accept) begin
            k_q <= k_is_last ? '0 : k_q + AW'(1);
            if (s_last != k_is_last) begin
                o_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1_q    <= 1'b0;
            addr1_q <= '0;
            last1_q <= 1'b0;
            o_valid <= 1'b0;
            o_addr  <= '0;
            o_done  <= 1'b0;
        end else begin
            v1_q    <= accept;
            o_valid <= v1_q;
            o_done  <= v1_q && last1_q;
            if (accept) begin
                addr1_q <= k_q;
                last1_q <= k_is_last;
            end
            if (v1_q) begin
                o_addr <= addr1_q;
            end
        end
    end

    bm_sat_shift #(
        .DWIDTH (DWIDTH),
        .PAR_SUB(1'b0)
    ) u_branch1 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_load  (accept),
        .i_shift (v1_q),
        .i_sys   (s_sys),
        .i_apr   (s_apr),
        .i_par   (s_par),
        .o_branch(o_branch1)
    );

    bm_sat_shift #(
        .DWIDTH (DWIDTH),
        .PAR_SUB(1'b1)
    ) u_branch2 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_load  (accept),
        .i_shift (v1_q),
        .i_sys   (s_sys),
        .i_apr   (s_apr),
        .i_par   (s_par),
        .o_branch(o_branch2)
    );

endmodule

// File: tb/tb_branch_metric_block.sv
// Directed bench for branch_metric_block with ROW_SIZE=8, DWIDTH=16: table of
// hand-computed branch pairs, a negedge monitor with an expected queue, and framing/reset sequences.
module tb_branch_metric_block;
    import siso_decoder_pkg::*;

    localparam int DW    = 16;
    localparam int ROW   = 8;
    localparam int AW    = 3;
    localparam int EXP_W = 52;

    typedef struct {
        logic signed [DW-1:0] sys;
        logic signed [DW-1:0] apr;
        logic signed [DW-1:0] par;
        logic signed [DW-1:0] b1;
        logic signed [DW-1:0] b2;
    } vec_t;

    logic          aclk;
    logic          aresetn;
    logic          i_start;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_sys;
    logic [DW-1:0] s_par;
    logic [DW-1:0] s_apr;
    logic          s_last;
    logic          o_valid;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_branch1;
    logic [DW-1:0] o_branch2;
    logic          o_done;
    logic          o_err;
    bm_state_t     dbg_state;

    vec_t             vecs[16];
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] last_e;
    logic [EXP_W-1:0] mon_e;
    int               total;
    int               bad;
    int               cyc_cnt;
    int               kk;

    branch_metric_block #(
        .DWIDTH  (DW),
        .ROW_SIZE(ROW)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .i_start  (i_start),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_sys    (s_sys),
        .s_par    (s_par),
        .s_apr    (s_apr),
        .s_last   (s_last),
        .o_valid  (o_valid),
        .o_addr   (o_addr),
        .o_branch1(o_branch1),
        .o_branch2(o_branch2),
        .o_done   (o_done),
        .o_err    (o_err),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial cyc_cnt = 0;
    always @(posedge aclk) cyc_cnt = cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total = total + 1;
        if (act !== exp_v) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Scoreboard: expected entry = {cycle[51:36], done[35], addr[34:32], b1[31:16], b2[15:0]}
    always @(negedge aclk) begin
        if (aresetn) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(o_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency", 32'(cyc_cnt), 32'(mon_e[51:36]));
                    chk("o_done", 32'(o_done), 32'(mon_e[35]));
                    chk("o_addr", 32'(o_addr), 32'(mon_e[34:32]));
                    chk("o_branch1", 32'(o_branch1), 32'(mon_e[31:16]));
                    chk("o_branch2", 32'(o_branch2), 32'(mon_e[15:0]));
                    last_e = mon_e;
                end
            end else begin
                if (exp_q.size() != 0 && int'(exp_q[0][51:36]) <= cyc_cnt) begin
                    chk("valid_missing", 32'(o_valid), 32'd1);
                    mon_e = exp_q.pop_front();
                end
                chk("hold_addr", 32'(o_addr), 32'(last_e[34:32]));
                chk("hold_b1", 32'(o_branch1), 32'(last_e[31:16]));
                chk("hold_b2", 32'(o_branch2), 32'(last_e[15:0]));
                chk("done_idle", 32'(o_done), 32'd0);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_cycle();
        s_valid = 1'b0;
        tick();
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        kk = 0;
    endtask

    task automatic send(input int idx, input logic last);
        s_valid = 1'b1;
        s_sys   = vecs[idx].sys;
        s_apr   = vecs[idx].apr;
        s_par   = vecs[idx].par;
        s_last  = last;
        exp_q.push_back({16'(cyc_cnt + 2), (kk == ROW - 1), 3'(kk), vecs[idx].b1, vecs[idx].b2});
        kk = (kk == ROW - 1) ? 0 : kk + 1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            idle_cycle();
            budget = budget - 1;
        end
        if (budget == 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        idle_cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_o_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_o_addr"}, 32'(o_addr), 32'd0);
        chk({tag, "_o_branch1"}, 32'(o_branch1), 32'd0);
        chk({tag, "_o_branch2"}, 32'(o_branch2), 32'd0);
        chk({tag, "_o_done"}, 32'(o_done), 32'd0);
        chk({tag, "_o_err"}, 32'(o_err), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        kk      = 0;
        last_e  = '0;
        aresetn = 1'b0;
        i_start = 1'b0;
        s_valid = 1'b0;
        s_sys   = '0;
        s_apr   = '0;
        s_par   = '0;
        s_last  = 1'b0;

        // sys, apr, par -> branch1, branch2 (hand-computed)
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{sys: 16'sd10, apr: 16'sd4, par: 16'sd6, b1: 16'sd10, b2: 16'sd4};
        end
        vecs[8]  = '{sys: 16'sd32767, apr: 16'sd32767, par: 16'sd32767, b1: 16'sd32767, b2: 16'sd16383};
        vecs[9]  = '{sys: 16'h8000, apr: 16'h8000, par: 16'h8000, b1: 16'h8000, b2: 16'hC000};
        vecs[10] = '{sys: -16'sd3, apr: 16'sd0, par: 16'sd0, b1: -16'sd2, b2: -16'sd2};
        vecs[11] = '{sys: 16'sd5, apr: 16'sd0, par: 16'sd0, b1: 16'sd2, b2: 16'sd2};
        vecs[12] = '{sys: 16'sd100, apr: -16'sd50, par: 16'sd30, b1: 16'sd40, b2: 16'sd10};
        vecs[13] = '{sys: -16'sd7, apr: 16'sd2, par: 16'sd4, b1: -16'sd1, b2: -16'sd5};
        vecs[14] = '{sys: 16'sd0, apr: 16'sd0, par: 16'sd1, b1: 16'sd0, b2: -16'sd1};
        vecs[15] = '{sys: 16'sd20000, apr: 16'sd20000, par: -16'sd30000, b1: 16'sd5000, b2: 16'sd32767};

        #1;
        chk_all_zero("reset");
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        chk("ready_before_start", 32'(s_ready), 32'd0);

        // Frame 1: constant LLRs, back-to-back samples
        do_start();
        chk("ready_run", 32'(s_ready), 32'd1);
        chk("state_run", 32'(dbg_state), 32'(ST_RUN));
        for (int i = 0; i < ROW; i++) begin
            send(i, i == ROW - 1);
        end
        chk("ready_flush", 32'(s_ready), 32'd0);
        chk("err_clean_frame", 32'(o_err), 32'd0);
        drain();
        chk("state_idle_after", 32'(dbg_state), 32'(ST_IDLE));

        // Frame 2: saturation / rounding vectors with s_valid gaps (1,0,0,1,...)
        do_start();
        for (int j = 0; j < ROW; j++) begin
            send(8 + j, j == ROW - 1);
            if (j % 2 == 0 && j != ROW - 1) begin
                idle_cycle();
                idle_cycle();
            end
        end
        drain();
        chk("err_gap_frame", 32'(o_err), 32'd0);

        // Frame 3: s_last early at k=5 (and missing at k=7)
        do_start();
        for (int k = 0; k < ROW; k++) begin
            send(0, k == 5);
            if (k == 4) chk("err_before_k5", 32'(o_err), 32'd0);
            if (k == 5) chk("err_at_k5", 32'(o_err), 32'd1);
        end
        chk("err_sticky", 32'(o_err), 32'd1);
        drain();
        chk("err_held_idle", 32'(o_err), 32'd1);
        do_start();
        chk("err_cleared_start", 32'(o_err), 32'd0);

        // Reset mid-frame with sample k=3 on the bus
        for (int k = 0; k < 3; k++) begin
            send(0, 1'b0);
        end
        s_valid = 1'b1;
        s_sys   = vecs[0].sys;
        s_apr   = vecs[0].apr;
        s_par   = vecs[0].par;
        s_last  = 1'b0;
        #2;
        aresetn = 1'b0;
        exp_q.delete();
        last_e = '0;
        kk     = 0;
        #1;
        chk_all_zero("midrst");
        tick();
        aresetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("ready_after_rst", 32'(s_ready), 32'd0);
            chk("state_after_rst", 32'(dbg_state), 32'(ST_IDLE));
        end
        s_valid = 1'b0;
        tick();

        // Recovery frame after reset
        do_start();
        for (int i = 0; i < ROW; i++) begin
            send(i, i == ROW - 1);
        end
        drain();
        chk("err_recovery", 32'(o_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_metric_block.md
BRANCH_METRIC_BLOCK -- requirements
Module: branch_metric_block

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, signed two's-complement width of all LLR inputs and branch outputs.
REQ-002 SHALL have parameter ROW_SIZE, default 3072, number of trellis steps k per frame.
REQ-003 SHALL have port aclk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_start  input  1  one-cycle frame-start pulse.
REQ-006 SHALL have port s_valid  input  1  input sample valid.
REQ-007 SHALL have port s_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port s_sys  input  DWIDTH  systematic LLR(k).
REQ-009 SHALL have port s_par  input  DWIDTH  parity LLR(k).
REQ-010 SHALL have port s_apr  input  DWIDTH  a-priori LLR(k).
REQ-011 SHALL have port s_last  input  1  producer marks final sample of frame.
REQ-012 SHALL have port o_valid  output  1  branch pair valid, to the alpha rows' i_valid.
REQ-013 SHALL have port o_addr  output  $clog2(ROW_SIZE)  trellis index k of the output pair.
REQ-014 SHALL have port o_branch1  output  DWIDTH  branch1(k).
REQ-015 SHALL have port o_branch2  output  DWIDTH  branch2(k).
REQ-016 SHALL have port o_done  output  1  one-cycle pulse with the final pair of a frame.
REQ-017 SHALL have port o_err  output  1  sticky frame-length error flag.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, FLUSH: IDLE->RUN on i_start; RUN->FLUSH on acceptance of sample ROW_SIZE-1; FLUSH->IDLE when the final pair has left the pipeline.
REQ-019 SHALL drive s_ready=1 only in RUN; a sample is accepted when s_valid && s_ready.
REQ-020 SHALL ignore i_start in RUN and FLUSH.
REQ-021 SHALL hold input counter k in 0..ROW_SIZE-1, clear it on i_start, and increment it per accepted sample.
REQ-022 SHALL compute at DWIDTH+2 bits: branch1 = (sys+apr+par) >>> 1 and branch2 = (sys+apr-par) >>> 1, arithmetic shift, rounding toward minus infinity.
REQ-023 SHALL saturate each result to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
REQ-024 SHALL present o_valid, o_addr=k, and both branches exactly 2 cycles after acceptance: stage 1 sums, stage 2 shifts and saturates.
REQ-025 SHALL have no backpressure from downstream; o_valid is a qualified strobe, and gaps in s_valid produce gaps in o_valid.
REQ-026 SHALL hold o_branch1, o_branch2 and o_addr stable when o_valid=0.
REQ-027 SHALL assert o_done together with the o_valid of o_addr=ROW_SIZE-1.
REQ-028 SHALL set o_err if s_last=1 is accepted at k!=ROW_SIZE-1, or s_last=0 is accepted at k=ROW_SIZE-1.
REQ-029 SHALL not change frame length on an o_err event; the frame always completes at ROW_SIZE samples.
REQ-030 SHALL clear o_err on accepted i_start.

Reset
REQ-031 SHALL on aresetn=0 immediately force FSM=IDLE, k=0, pipeline valids=0, s_ready=0, o_valid=0, o_addr=0, o_branch1=0, o_branch2=0, o_done=0, o_err=0.
REQ-032 SHALL discard an in-flight frame on reset mid-frame; no o_valid or o_done for it after release.
REQ-033 SHALL require a fresh i_start after reset release before accepting samples.

Structure
REQ-034 SHALL take the DWIDTH/ROW_SIZE defaults, FSM state encoding and saturation width constants from the shared siso_decoder package.
REQ-035 SHALL implement the add-shift-saturate datapath as one sub-module, bm_sat_shift, instantiated twice with the parity sign as parameter.

Verification
REQ-036 SHALL cover: ROW_SIZE=8, sys=10, apr=4, par=6 each k -> branch1=10, branch2=4, o_addr 0..7, o_done with addr 7, latency 2.
REQ-037 SHALL cover: DWIDTH=16, sys=apr=par=32767 -> branch1=32767 (saturated), branch2=16383; sys=apr=par=-32768 -> branch1=-32768, branch2=-16384.
REQ-038 SHALL cover: odd sum, sys=-3, apr=0, par=0 -> branch1=branch2=-2.
REQ-039 SHALL cover: s_valid toggled 1,0,0,1 -> o_valid pattern identical, delayed 2 cycles; outputs held during gaps.
REQ-040 SHALL cover: s_last at k=5 with ROW_SIZE=8 -> o_err=1 from k=5 onward, frame still ends at addr 7; next i_start clears o_err.
REQ-041 SHALL cover: aresetn low at k=3 -> all outputs 0 immediately, s_ready=0 until the next i_start.
